alu_arbiter: RTL

Shares the single multi-cycle ALU (alu_v) between two requesters: port 0 is the CPU execute stage, port 1 is the auxiliary/interrupt unit.
- Arbitrates requests, drives the ALU operand/opcode bus, and holds enable_alu for the opcode's fixed latency.
- Captures m2/FR_out and returns them to the winner with a one-cycle ack.
- Guarantees an enable_alu low gap between operations so every operation starts on a fresh rising edge of enable.

---
 rtl/alu_arbiter.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// +---------------------------------------------------------------------------+
// | Module   : alu_arbiter                                                    |
// | Purpose  : Two-port arbiter that shares one multi-cycle ALU, sequencing  |
// |            enable/operands per opcode latency and returning results.     |
// | Options  : define ALU_ARB_FIXED_PRIO_EN for fixed port-0 priority        |
// |            (default is round-robin).                                     |
// | Revision : 1.0  initial release                                          |
// +---------------------------------------------------------------------------+
`default_nettype none

module alu_arbiter #(
  parameter int GAP_CYCLES = 1,
  parameter int LAT_W      = 3
) (
  input  logic        wire_clock,
  input  logic        wire_reset_n,
  input  logic        req0,
  input  logic        req1,
  input  logic [5:0]  op0,
  input  logic [5:0]  op1,
  input  logic [15:0] a0,
  input  logic [15:0] a1,
  input  logic [15:0] b0,
  input  logic [15:0] b1,
  input  logic [15:0] fr0,
  input  logic [15:0] fr1,
  input  logic [4:0]  ctl0,
  input  logic [4:0]  ctl1,
  output logic        ack0,
  output logic        ack1,
  output logic [15:0] res_out,
  output logic [15:0] fr_out,
  output logic        err_out,
  output logic        enable_alu,
  output logic [5:0]  alu_op,
  output logic [15:0] alu_m3,
  output logic [15:0] alu_m4,
  output logic [15:0] alu_fr_in,
  output logic [4:0]  alu_ctl,
  input  logic [15:0] alu_m2,
  input  logic [15:0] alu_fr,
  output logic        busy
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GRANT   = 3'd1,
    S_RUN     = 3'd2,
    S_CAPTURE = 3'd3,
    S_GAP     = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_win;
  logic [LAT_W-1:0]   r_cnt;
  logic [GAP_W-1:0]   r_gap;
  logic               r_en;
  logic               r_ack0;
  logic               r_ack1;
  logic               r_err;
  logic [5:0]         r_op;
  logic [15:0]        r_m3;
  logic [15:0]        r_m4;
  logic [15:0]        r_fr_in;
  logic [4:0]         r_ctl;
  logic [15:0]        r_res;
  logic [15:0]        r_fr_out;
  logic               w_pick1;
  logic [5:0]         w_sel_op;
  logic [LAT_W:0]     w_lat;

  // {accept, L}: accept=0 marks an opcode the ALU would never finish
  function automatic logic [LAT_W:0] lat_lookup(input logic [5:0] op);
    case (op)
      6'b000110, 6'b010110, 6'b010000:           lat_lookup = {1'b1, LAT_W'(1)};
      6'b100001:                                 lat_lookup = {1'b1, LAT_W'(3)};
      6'b100000, 6'b100010, 6'b100011, 6'b100101,
      6'b100100, 6'b010010, 6'b010011, 6'b010100,
      6'b010101:                                 lat_lookup = {1'b1, LAT_W'(2)};
      default:                                   lat_lookup = '0;
    endcase
  endfunction

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign w_pick1 = req1 & ~req0;
`else
  logic r_last;

  assign w_pick1 = req1 & (~req0 | ~r_last);

  always_ff @(posedge wire_clock or negedge wire_reset_n) begin
    if (!wire_reset_n) begin
      r_last <= 1'b1;
    end else if (r_state == S_IDLE && (req0 || req1)) begin
      r_last <= w_pick1;
    end
  end
`endif

  assign w_sel_op = r_win ? op1 : op0;
  assign w_lat    = lat_lookup(w_sel_op);

  always_ff @(posedge wire_clock or negedge wire_reset_n) begin
    if (!wire_reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (req0 || req1) w_next = S_GRANT;
      S_GRANT:   w_next = w_lat[LAT_W] ? S_RUN : S_CAPTURE;
      S_RUN:     if (r_cnt == '0) w_next = S_CAPTURE;
      S_CAPTURE: w_next = (GAP_CYCLES > 1) ? S_GAP : S_IDLE;
      S_GAP:     if (r_gap == '0) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // RUN lasts L+1 cycles (cnt runs L..0) to cover the ALU's negedge stage
  always_ff @(posedge wire_clock or negedge wire_reset_n) begin
    if (!wire_reset_n) begin
      r_win    <= 1'b0;
      r_cnt    <= '0;
      r_gap    <= '0;
      r_en     <= 1'b0;
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_err    <= 1'b0;
      r_op     <= '0;
      r_m3     <= '0;
      r_m4     <= '0;
      r_fr_in  <= '0;
      r_ctl    <= '0;
      r_res    <= '0;
      r_fr_out <= '0;
    end else begin
      r_en   <= (w_next == S_RUN);
      r_ack0 <= (w_next == S_CAPTURE) && !r_win;
      r_ack1 <= (w_next == S_CAPTURE) && r_win;
      case (r_state)
        S_IDLE: begin
          if (req0 || req1) r_win <= w_pick1;
        end
        S_GRANT: begin
          r_op    <= w_sel_op;
          r_m3    <= r_win ? a1 : a0;
          r_m4    <= r_win ? b1 : b0;
          r_fr_in <= r_win ? fr1 : fr0;
          r_ctl   <= r_win ? ctl1 : ctl0;
          r_cnt   <= w_lat[LAT_W-1:0];
          if (!w_lat[LAT_W]) r_err <= 1'b1;
        end
        S_RUN: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_res    <= alu_m2;
            r_fr_out <= alu_fr;
            r_err    <= 1'b0;
          end
        end
        S_CAPTURE: begin
          if (GAP_CYCLES > 1) r_gap <= GAP_W'(GAP_CYCLES - 2);
        end
        S_GAP: begin
          r_gap <= r_gap - 1'b1;
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  assign ack0       = r_ack0;
  assign ack1       = r_ack1;
  assign res_out    = r_res;
  assign fr_out     = r_fr_out;
  assign err_out    = r_err;
  assign enable_alu = r_en;
  assign alu_op     = r_op;
  assign alu_m3     = r_m3;
  assign alu_m4     = r_m4;
  assign alu_fr_in  = r_fr_in;
  assign alu_ctl    = r_ctl;
  assign busy       = (r_state != S_IDLE);

endmodule

`default_nettype wire
